shift_add_mult_ctrl: RTL and testbench

//  Sequential shift-and-add controller for the 8-bit multiplier. It sits directly upstream of the

---
 rtl/shift_add_mult_ctrl.sv | 147 ++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add multiply controller that drives an external registered pipelined adder.
// One partial product is added per set multiplier bit. The product is returned on a valid/ready handshake.
module shift_add_mult_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADD_W   = 32,
  parameter int ADD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [ADD_W-1:0]   add_a,
  output logic [ADD_W-1:0]   add_b,
  output logic               add_cin,
  input  logic [ADD_W-1:0]   add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [ADD_W-1:0]     acc_reg, acc_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [CNT_W-1:0]     wcnt_reg, wcnt_next;
  logic [ADD_W-1:0]     add_a_reg, add_a_next;
  logic [ADD_W-1:0]     add_b_reg, add_b_next;
  logic                 add_cin_reg, add_cin_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
  logic                 out_valid_reg, out_valid_next;

  // Carry-out can never be set while the product fits in the adder width.
  logic unused_cout;
  assign unused_cout = add_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      idx_reg       <= '0;
      wcnt_reg      <= '0;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      add_cin_reg   <= 1'b0;
      product_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      acc_reg       <= acc_next;
      idx_reg       <= idx_next;
      wcnt_reg      <= wcnt_next;
      add_a_reg     <= add_a_next;
      add_b_reg     <= add_b_next;
      add_cin_reg   <= add_cin_next;
      product_reg   <= product_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    acc_next       = acc_reg;
    idx_next       = idx_reg;
    wcnt_next      = wcnt_reg;
    add_a_next     = add_a_reg;
    add_b_next     = add_b_reg;
    add_cin_next   = add_cin_reg;
    product_next   = product_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a_in;
          b_next     = b_in;
          acc_next   = '0;
          idx_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (b_reg[idx_reg]) begin
          add_a_next   = acc_reg;
          add_b_next   = ADD_W'(a_reg) << idx_reg;
          add_cin_next = 1'b0;
          wcnt_next    = LAT_CNT;
          state_next   = WAIT;
        end else if (idx_reg == LAST_IDX) begin
          product_next   = acc_reg[2*WIDTH-1:0];
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      WAIT: begin
        wcnt_next = wcnt_reg - 1'b1;
        if (wcnt_reg == CNT_ONE) begin
          acc_next = add_sum;
          // On the last bit the fresh sum goes straight out, since acc updates on this same edge.
          if (idx_reg == LAST_IDX) begin
            product_next   = add_sum[2*WIDTH-1:0];
            out_valid_next = 1'b1;
            state_next     = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = SCAN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE);
  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign add_cin   = add_cin_reg;
  assign product   = product_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: table vectors, hand-written corner sequences and a random run.
// Expected products and latencies are queued when an operand pair is accepted and checked as results come back.
module tb_shift_add_mult_ctrl;
  localparam int WIDTH   = 8;
  localparam int ADD_W   = 32;
  localparam int ADD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        in_ready, add_cin, add_cout, out_valid, busy;
  logic [31:0] add_a, add_b, add_sum;
  logic [15:0] product;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(WIDTH), .ADD_W(ADD_W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  // Adder with one internal register: the sum is usable ADD_LAT=2 cycles after the controller registers its operands.
  always_ff @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
    int          acc_cyc;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ov_rises = 0;
  bit          rand_rdy = 1'b0;
  exp_t        sb[$];
  logic [31:0] addb_log[$];
  vec_t        vecs[11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin : monitor
    logic        ov_prev;
    logic [31:0] addb_prev;
    exp_t        e;
    ov_prev   = 1'b0;
    addb_prev = '0;
    forever begin
      @(negedge clk);
      if (add_b !== addb_prev) begin
        addb_log.push_back(add_b);
        addb_prev = add_b;
      end
      if (out_valid && !ov_prev) begin
        ov_rises++;
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        $display("op %02h*%02h -> %04h (expect %04h)", e.a, e.b, product, e.prod);
        chk("product", product, e.prod);
      end
      ov_prev = out_valid;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod,
                       input int lat, output int waited);
    exp_t e;
    waited   = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 400) break;
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (in_ready) begin
      e.a = a; e.b = b; e.prod = prod; e.lat = lat; e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end else begin
      chk("accept_timeout", waited, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin : main
    int w, n, r0;
    logic [7:0] ra, rb;
    vecs[0]  = '{8'h0F, 8'h0A, 16'h0096, 12};
    vecs[1]  = '{8'hFF, 8'hFF, 16'hFE01, 24};
    vecs[2]  = '{8'hAB, 8'h00, 16'h0000, 8};
    vecs[3]  = '{8'h01, 8'h80, 16'h0080, 10};
    vecs[4]  = '{8'h80, 8'h01, 16'h0080, 10};
    vecs[5]  = '{8'hFF, 8'h01, 16'h00FF, 10};
    vecs[6]  = '{8'h00, 8'hFF, 16'h0000, 24};
    vecs[7]  = '{8'h12, 8'h34, 16'h03A8, 14};
    vecs[8]  = '{8'h03, 8'h05, 16'h000F, 12};
    vecs[9]  = '{8'h80, 8'h80, 16'h4000, 10};
    vecs[10] = '{8'hFF, 8'h80, 16'h7F80, 10};

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // 0x0F*0x0A: two adds, add_b issues 0x1E then 0x78
    addb_log.delete();
    do_op(8'h0F, 8'h0A, 16'h0096, 12, w);
    drain();
    chk("t2_add_count", addb_log.size(), 2);
    if (addb_log.size() == 2) begin
      chk("t2_add_b_first", addb_log[0], 32'h1E);
      chk("t2_add_b_second", addb_log[1], 32'h78);
    end
    chk("t2_add_a_last", add_a, 32'h1E);
    chk("t2_add_cin", add_cin, 0);
    chk("t2_product_held", product, 16'h0096);

    // Two-cycle reset while idle clears the datapath registers
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t1_product", product, 0);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_add_a", add_a, 0);
    chk("t1_add_b", add_b, 0);
    chk("t1_in_ready", in_ready, 1);

    // Zero multiplier: no add issued
    @(posedge clk); #1;
    addb_log.delete();
    do_op(8'hAB, 8'h00, 16'h0000, 8, w);
    drain();
    chk("t3_no_add", addb_log.size(), 0);

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, w);
      drain();
    end

    // Back-pressure: product held, new operands ignored while DONE
    out_ready = 1'b0;
    do_op(8'h12, 8'h34, 16'h03A8, 14, w);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_out_valid", out_valid, 1);
    in_valid = 1'b1;
    a_in     = 8'h77;
    b_in     = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_product", product, 16'h03A8);
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_busy", busy, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_in_ready_after", in_ready, 1);
    chk("t4_out_valid_cleared", out_valid, 0);
    do_op(8'h03, 8'h05, 16'h000F, 12, w);
    chk("t4_accept_next_cycle", w, 0);
    drain();

    // Reset during WAIT aborts the operation
    do_op(8'h55, 8'h55, 16'h1C39, 16, w);
    @(posedge clk); #1;
    chk("t5_busy_in_wait", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    r0 = ov_rises;
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_out_valid", ov_rises - r0, 0);
    do_op(8'h03, 8'h05, 16'h000F, 12, w);
    drain();

    // Random back-to-back operations with random out_ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, 16'(16'(ra) * 16'(rb)), WIDTH + ADD_LAT * $countones(rb), w);
    end
    rand_rdy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
